// File: rtl/adder_pkg.sv
// Shared widths and control state encoding for the 8-bit accumulator slice.
package adder_pkg;

  localparam int DATA_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic {
    ACCUM  = 1'b0,
    RESULT = 1'b1
  } acc_state_t;

endpackage

// File: rtl/accumulator_8_bits_seq_if.sv
// Operand-in / result-out handshake bundle; slave is the accumulator, master the producer/consumer.
interface accumulator_8_bits_seq_if;
  import adder_pkg::*;

  logic              IN_VALID;
  logic              IN_READY;
  logic [DATA_W-1:0] IN_DATA;
  logic              FLUSH;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic [DATA_W-1:0] OUT_SUM;
  logic              OUT_CARRY;
  logic [CNT_W-1:0]  OUT_COUNT;

  modport slave (
    input  IN_VALID, IN_DATA, FLUSH, OUT_READY,
    output IN_READY, OUT_VALID, OUT_SUM, OUT_CARRY, OUT_COUNT
  );

  modport master (
    output IN_VALID, IN_DATA, FLUSH, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_SUM, OUT_CARRY, OUT_COUNT
  );

endinterface

// File: rtl/full_adder_8_bits_behavior.sv
// Unsigned ripple-carry adder: one full-adder cell per bit, carry chained LSB to MSB.
module full_adder_8_bits_behavior
  import adder_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              cin_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              cout_o
);

  logic [DATA_W:0] carry;

  assign carry[0] = cin_i;

  for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
    assign sum_o[gi]    = a_i[gi] ^ b_i[gi] ^ carry[gi];
    assign carry[gi+1]  = (a_i[gi] & b_i[gi]) | (carry[gi] & (a_i[gi] ^ b_i[gi]));
  end

  assign cout_o = carry[DATA_W];

endmodule

// File: rtl/accumulator_8_bits_seq.sv
// Batch accumulator: folds accepted operands into a running sum with a sticky carry,
// then holds sum/carry/count on the output handshake until consumed.
module accumulator_8_bits_seq
  import adder_pkg::*;
#(
  parameter int BATCH_LEN = 4
) (
  input  logic                        CLK,
  input  logic                        RST,
  accumulator_8_bits_seq_if.slave     bus
);

  if (BATCH_LEN < 1 || BATCH_LEN > 15) begin : g_bad_batch_len
    $error("BATCH_LEN must be in 1..15");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH_LEN - 1);

  acc_state_t        state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready_q, in_ready_d;

  logic [DATA_W-1:0] add_sum;
  logic              add_cout;
  logic              handshake;
  logic              close_batch;

  full_adder_8_bits_behavior u_adder (
    .a_i    (acc_q),
    .b_i    (bus.IN_DATA),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // in_ready_q is a register so IN_READY reads 0 for the reset cycle without a path from RST.
  assign handshake   = bus.IN_VALID & in_ready_q;
  assign close_batch = (handshake && cnt_q == LAST_CNT) ||
                       (bus.FLUSH && (cnt_q != '0 || handshake));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      ACCUM: begin
        if (handshake) begin
          acc_d   = add_sum;
          carry_d = carry_q | add_cout;
          cnt_d   = cnt_q + 1'b1;
        end
        if (close_batch) state_d = RESULT;
      end
      RESULT: begin
        if (bus.OUT_READY) begin
          acc_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
    in_ready_d = (state_d == ACCUM);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.IN_READY  = in_ready_q;
  assign bus.OUT_VALID = (state_q == RESULT);
  assign bus.OUT_SUM   = acc_q;
  assign bus.OUT_CARRY = carry_q;
  assign bus.OUT_COUNT = cnt_q;

endmodule

// File: tb/tb_accumulator_8_bits_seq.sv
// Directed bench for accumulator_8_bits_seq with BATCH_LEN=4.
module tb_accumulator_8_bits_seq;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  accumulator_8_bits_seq_if bus ();

  accumulator_8_bits_seq #(.BATCH_LEN(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic f);
    bus.IN_VALID = 1'b1;
    bus.IN_DATA  = d;
    bus.FLUSH    = f;
    tick();
    bus.IN_VALID = 1'b0;
    bus.FLUSH    = 1'b0;
    $display("op data=%0d flush=%0d -> out_valid=%0b sum=%0d cnt=%0d", d, f, bus.OUT_VALID, bus.OUT_SUM, bus.OUT_COUNT);
  endtask

  task automatic consume();
    bus.OUT_READY = 1'b1;
    tick();
    bus.OUT_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", bus.IN_READY); end
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", bus.OUT_VALID); end
    checks++; if (bus.OUT_SUM !== 8'd0 || bus.OUT_CARRY !== 1'b0 || bus.OUT_COUNT !== 4'd0) begin
      errors++; $display("FAIL rst_outputs got sum=%0d carry=%b cnt=%0d exp 0/0/0", bus.OUT_SUM, bus.OUT_CARRY, bus.OUT_COUNT);
    end
    RST = 1'b0;
    tick();
    checks++; if (bus.IN_READY !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.IN_READY); end
    $display("reset done");
  endtask

  task automatic test_back_to_back();
    bus.OUT_READY = 1'b1;
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL b2b_early_valid got=%b exp=0", bus.OUT_VALID); end
    send(8'd40, 1'b0);
    checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", bus.OUT_VALID); end
    checks++; if (bus.OUT_SUM !== 8'd100) begin errors++; $display("FAIL b2b_sum got=%0d exp=100", bus.OUT_SUM); end
    checks++; if (bus.OUT_CARRY !== 1'b0) begin errors++; $display("FAIL b2b_carry got=%b exp=0", bus.OUT_CARRY); end
    checks++; if (bus.OUT_COUNT !== 4'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", bus.OUT_COUNT); end
    checks++; if (bus.IN_READY !== 1'b0) begin errors++; $display("FAIL b2b_in_ready_result got=%b exp=0", bus.IN_READY); end
    tick();
    bus.OUT_READY = 1'b0;
    checks++; if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
      errors++; $display("FAIL b2b_return got in_ready=%b out_valid=%b exp 1/0", bus.IN_READY, bus.OUT_VALID);
    end
    checks++; if (bus.OUT_SUM !== 8'd0 || bus.OUT_COUNT !== 4'd0) begin
      errors++; $display("FAIL b2b_clear got sum=%0d cnt=%0d exp 0/0", bus.OUT_SUM, bus.OUT_COUNT);
    end
  endtask

  task automatic test_overflow();
    send(8'd200, 1'b0);
    send(8'd100, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", bus.OUT_VALID); end
    checks++; if (bus.OUT_SUM !== 8'd46) begin errors++; $display("FAIL ovf_sum got=%0d exp=46", bus.OUT_SUM); end
    checks++; if (bus.OUT_CARRY !== 1'b1) begin errors++; $display("FAIL ovf_carry got=%b exp=1", bus.OUT_CARRY); end
    checks++; if (bus.OUT_COUNT !== 4'd4) begin errors++; $display("FAIL ovf_count got=%0d exp=4", bus.OUT_COUNT); end
    consume();
    checks++; if (bus.OUT_CARRY !== 1'b0) begin errors++; $display("FAIL ovf_carry_clear got=%b exp=0", bus.OUT_CARRY); end
  endtask

  task automatic test_backpressure();
    send(8'd1, 1'b0);
    send(8'd2, 1'b0);
    send(8'd3, 1'b0);
    send(8'd4, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.IN_VALID = 1'b1;
      bus.IN_DATA  = 8'hA0 + 8'(i);
      bus.FLUSH    = 1'b1;
      tick();
      $display("stall cycle %0d out_valid=%0b sum=%0d in_ready=%0b", i, bus.OUT_VALID, bus.OUT_SUM, bus.IN_READY);
      checks++; if (bus.OUT_VALID !== 1'b1 || bus.IN_READY !== 1'b0) begin
        errors++; $display("FAIL bp_handshake cyc=%0d got out_valid=%b in_ready=%b exp 1/0", i, bus.OUT_VALID, bus.IN_READY);
      end
      checks++; if (bus.OUT_SUM !== 8'd10 || bus.OUT_COUNT !== 4'd4 || bus.OUT_CARRY !== 1'b0) begin
        errors++; $display("FAIL bp_stable cyc=%0d got sum=%0d cnt=%0d carry=%b exp 10/4/0", i, bus.OUT_SUM, bus.OUT_COUNT, bus.OUT_CARRY);
      end
    end
    bus.IN_VALID = 1'b0;
    bus.FLUSH    = 1'b0;
    consume();
    checks++; if (bus.OUT_VALID !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", bus.OUT_VALID); end
    send(8'd10, 1'b0);
    send(8'd20, 1'b0);
    send(8'd30, 1'b0);
    send(8'd40, 1'b0);
    checks++; if (bus.OUT_SUM !== 8'd100 || bus.OUT_COUNT !== 4'd4) begin
      errors++; $display("FAIL bp_next_batch got sum=%0d cnt=%0d exp 100/4", bus.OUT_SUM, bus.OUT_COUNT);
    end
    consume();
  endtask

  task automatic test_flush();
    send(8'd5, 1'b0);
    send(8'd7, 1'b0);
    bus.FLUSH = 1'b1;
    tick();
    bus.FLUSH = 1'b0;
    checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL flush_valid got=%b exp=1", bus.OUT_VALID); end
    checks++; if (bus.OUT_SUM !== 8'd12 || bus.OUT_COUNT !== 4'd2) begin
      errors++; $display("FAIL flush_result got sum=%0d cnt=%0d exp 12/2", bus.OUT_SUM, bus.OUT_COUNT);
    end
    consume();
    send(8'd5, 1'b0);
    send(8'd3, 1'b1);
    checks++; if (bus.OUT_VALID !== 1'b1) begin errors++; $display("FAIL flush_coinc_valid got=%b exp=1", bus.OUT_VALID); end
    checks++; if (bus.OUT_SUM !== 8'd8 || bus.OUT_COUNT !== 4'd2) begin
      errors++; $display("FAIL flush_coinc_result got sum=%0d cnt=%0d exp 8/2", bus.OUT_SUM, bus.OUT_COUNT);
    end
    consume();
    bus.FLUSH = 1'b1;
    tick();
    tick();
    bus.FLUSH = 1'b0;
    $display("empty flush out_valid=%0b in_ready=%0b", bus.OUT_VALID, bus.IN_READY);
    checks++; if (bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b1) begin
      errors++; $display("FAIL flush_empty got out_valid=%b in_ready=%b exp 0/1", bus.OUT_VALID, bus.IN_READY);
    end
  endtask

  task automatic test_reset_mid();
    send(8'd9, 1'b0);
    send(8'd9, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (bus.OUT_SUM !== 8'd0 || bus.OUT_COUNT !== 4'd0 || bus.OUT_VALID !== 1'b0 || bus.IN_READY !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs got sum=%0d cnt=%0d valid=%b in_ready=%b exp 0/0/0/0",
                         bus.OUT_SUM, bus.OUT_COUNT, bus.OUT_VALID, bus.IN_READY);
    end
    tick();
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    send(8'd1, 1'b0);
    checks++; if (bus.OUT_VALID !== 1'b1 || bus.OUT_SUM !== 8'd4 || bus.OUT_COUNT !== 4'd4 || bus.OUT_CARRY !== 1'b0) begin
      errors++; $display("FAIL midrst_batch got valid=%b sum=%0d cnt=%0d carry=%b exp 1/4/4/0",
                         bus.OUT_VALID, bus.OUT_SUM, bus.OUT_COUNT, bus.OUT_CARRY);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++; if (bus.OUT_VALID !== 1'b0 || bus.OUT_SUM !== 8'd0) begin
      errors++; $display("FAIL result_rst got valid=%b sum=%0d exp 0/0", bus.OUT_VALID, bus.OUT_SUM);
    end
    tick();
  endtask

  initial begin
    bus.IN_VALID  = 1'b0;
    bus.IN_DATA   = 8'd0;
    bus.FLUSH     = 1'b0;
    bus.OUT_READY = 1'b0;
    test_reset();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
